// File: rtl/inst_mem_stream_loader.sv
// Instruction memory filled by a valid/ready word stream. It serves two-word fetches
// with a 1-cycle latency and returns NOP_WORD for any address outside the loaded range.
module inst_mem_stream_loader #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 20,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic              load_valid,
  input  logic              load_last,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              load_done,
  output logic              load_overflow,
  output logic [ADDR_W:0]   load_count,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_data,
  output logic [DATA_W-1:0] fetch_next,
  output logic              fetch_valid,
  output logic              fetch_oob,
  output logic              busy
);

  localparam int                DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] TOP_ADDR = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_READY = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   word_cnt;
  logic [ADDR_W-1:0] range_lo;
  logic [ADDR_W:0]   range_cnt;

  logic              accept;
  logic              final_word;
  logic [ADDR_W-1:0] fetch_addr_p1;
  logic              cur_in;
  logic              nxt_in;

  // Range test runs one bit wider than the address, so addr+1 past the top of
  // memory falls outside every range instead of wrapping to 0.
  function automatic logic in_range(input logic [ADDR_W:0]   a,
                                    input logic [ADDR_W-1:0] lo,
                                    input logic [ADDR_W:0]   cnt);
    logic [ADDR_W:0] lo_x;
    lo_x = {1'b0, lo};
    return (a >= lo_x) && ((a - lo_x) < cnt);
  endfunction

  assign accept        = load_valid & load_ready;
  assign final_word    = load_last | (wr_ptr == TOP_ADDR);
  assign fetch_addr_p1 = fetch_addr + ADDR_W'(1);

  always_comb begin
    cur_in = in_range({1'b0, fetch_addr}, range_lo, range_cnt);
    nxt_in = in_range({1'b0, fetch_addr} + (ADDR_W + 1)'(1), range_lo, range_cnt);
  end

  // NOTE: the storage array has no reset. Clearing it would need a per-word reset
  // network and would prevent RAM inference, and the range check already masks stale words.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= load_data;
  end

  // NOTE: every state register uses non-blocking assignment. Pulse outputs take a
  // default at the top of the block, and the case arms only assert them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      wr_ptr        <= '0;
      base_q        <= '0;
      word_cnt      <= '0;
      range_lo      <= '0;
      range_cnt     <= '0;
      load_ready    <= 1'b0;
      load_done     <= 1'b0;
      load_overflow <= 1'b0;
      load_count    <= '0;
      fetch_data    <= NOP_WORD;
      fetch_next    <= NOP_WORD;
      fetch_valid   <= 1'b0;
      fetch_oob     <= 1'b0;
      busy          <= 1'b0;
    end else begin
      load_done   <= 1'b0;
      fetch_valid <= 1'b0;
      fetch_oob   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (load_start) begin
            state         <= S_LOAD;
            wr_ptr        <= load_base;
            base_q        <= load_base;
            word_cnt      <= '0;
            load_overflow <= 1'b0;
            load_ready    <= 1'b1;
            busy          <= 1'b1;
          end
        end
        S_READY: begin
          // A fetch issued together with load_start still sees the old image.
          if (fetch_en) begin
            fetch_valid <= 1'b1;
            fetch_oob   <= ~cur_in;
            fetch_data  <= cur_in ? mem[fetch_addr]    : NOP_WORD;
            fetch_next  <= nxt_in ? mem[fetch_addr_p1] : NOP_WORD;
          end
          if (load_start) begin
            state         <= S_LOAD;
            wr_ptr        <= load_base;
            base_q        <= load_base;
            word_cnt      <= '0;
            load_overflow <= 1'b0;
            load_ready    <= 1'b1;
            busy          <= 1'b1;
          end
        end
        S_LOAD: begin
          if (accept) begin
            word_cnt <= word_cnt + (ADDR_W + 1)'(1);
            if (final_word) begin
              state         <= S_READY;
              load_ready    <= 1'b0;
              busy          <= 1'b0;
              load_done     <= 1'b1;
              load_count    <= word_cnt + (ADDR_W + 1)'(1);
              range_lo      <= base_q;
              range_cnt     <= word_cnt + (ADDR_W + 1)'(1);
              load_overflow <= ~load_last;
            end else begin
              wr_ptr <= wr_ptr + ADDR_W'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_mem_stream_loader.sv
// Randomised bench for inst_mem_stream_loader. A sparse memory image and a loaded-range
// model predict every fetch; a second instance with ADDR_W=4 exercises the top-of-memory overflow.
module tb_inst_mem_stream_loader;

  localparam int              AW   = 20;
  localparam int              DW   = 16;
  localparam int              TOPA = (1 << AW) - 1;
  localparam logic [DW-1:0]   NOP  = 16'h0000;

  logic          clk, rst_n;
  logic          load_start, load_valid, load_last, load_ready, load_done, load_overflow;
  logic [AW-1:0] load_base, fetch_addr;
  logic [DW-1:0] load_data, fetch_data, fetch_next;
  logic [AW:0]   load_count;
  logic          fetch_en, fetch_valid, fetch_oob, busy;

  logic          s_load_start, s_load_valid, s_load_last, s_load_ready, s_load_done, s_load_overflow;
  logic [3:0]    s_load_base, s_fetch_addr;
  logic [DW-1:0] s_load_data, s_fetch_data, s_fetch_next;
  logic [4:0]    s_load_count;
  logic          s_fetch_en, s_fetch_valid, s_fetch_oob, s_busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] m_mem [int];
  int            m_lo  = 0;
  int            m_cnt = 0;

  inst_mem_stream_loader #(.DATA_W(DW), .ADDR_W(AW), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_start(load_start), .load_base(load_base), .load_valid(load_valid),
    .load_last(load_last), .load_data(load_data), .load_ready(load_ready),
    .load_done(load_done), .load_overflow(load_overflow), .load_count(load_count),
    .fetch_en(fetch_en), .fetch_addr(fetch_addr), .fetch_data(fetch_data),
    .fetch_next(fetch_next), .fetch_valid(fetch_valid), .fetch_oob(fetch_oob), .busy(busy)
  );

  inst_mem_stream_loader #(.DATA_W(DW), .ADDR_W(4), .NOP_WORD(NOP)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .load_start(s_load_start), .load_base(s_load_base), .load_valid(s_load_valid),
    .load_last(s_load_last), .load_data(s_load_data), .load_ready(s_load_ready),
    .load_done(s_load_done), .load_overflow(s_load_overflow), .load_count(s_load_count),
    .fetch_en(s_fetch_en), .fetch_addr(s_fetch_addr), .fetch_data(s_fetch_data),
    .fetch_next(s_fetch_next), .fetch_valid(s_fetch_valid), .fetch_oob(s_fetch_oob), .busy(s_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit m_in(input int a);
    return (a >= m_lo) && (a < m_lo + m_cnt) && (a <= TOPA);
  endfunction

  function automatic logic [DW-1:0] m_read(input int a);
    if (m_in(a) && m_mem.exists(a)) return m_mem[a];
    return NOP;
  endfunction

  // One fetch, then one idle cycle in which the data outputs must hold.
  task automatic do_fetch(input int a, input string nm);
    logic [DW-1:0] ed, en;
    logic          eo;
    ed = m_read(a);
    en = m_read(a + 1);
    eo = ~m_in(a);
    fetch_en = 1'b1; fetch_addr = AW'(a);
    tick();
    fetch_en = 1'b0;
    n_cmp++; if (fetch_valid !== 1'b1) begin n_bad++; $display("FAIL %s valid: got %b want 1", nm, fetch_valid); end
    n_cmp++; if (fetch_oob !== eo) begin n_bad++; $display("FAIL %s oob @%h: got %b want %b", nm, a, fetch_oob, eo); end
    n_cmp++; if (fetch_data !== ed) begin n_bad++; $display("FAIL %s data @%h: got %h want %h", nm, a, fetch_data, ed); end
    n_cmp++; if (fetch_next !== en) begin n_bad++; $display("FAIL %s next @%h: got %h want %h", nm, a, fetch_next, en); end
    tick();
    n_cmp++; if (fetch_valid !== 1'b0) begin n_bad++; $display("FAIL %s idle valid: got %b want 0", nm, fetch_valid); end
    n_cmp++; if (fetch_data !== ed) begin n_bad++; $display("FAIL %s hold data: got %h want %h", nm, fetch_data, ed); end
  endtask

  // Streams one session. Without use_last the stream runs until the top of memory.
  task automatic do_load(input int base, input int n, input bit use_last, input bit toggle,
                         input bit fixed, input bit co_fetch, input int co_addr);
    int            acc, cyc, exp_acc;
    bit            ended, phase, v;
    logic [DW-1:0] d;
    logic [AW:0]   ec;
    logic          eovf;
    acc = 0; cyc = 0; ended = 0; phase = 1;
    exp_acc = use_last ? n : (TOPA - base + 1);
    eovf    = ~use_last;
    load_start = 1'b1; load_base = AW'(base);
    if (co_fetch) begin fetch_en = 1'b1; fetch_addr = AW'(co_addr); end
    tick();
    load_start = 1'b0; fetch_en = 1'b0;
    if (co_fetch) begin
      n_cmp++; if (fetch_valid !== 1'b1) begin n_bad++; $display("FAIL cofetch valid: got %b want 1", fetch_valid); end
      n_cmp++; if (fetch_data !== m_read(co_addr)) begin n_bad++; $display("FAIL cofetch data: got %h want %h", fetch_data, m_read(co_addr)); end
      n_cmp++; if (fetch_next !== m_read(co_addr + 1)) begin n_bad++; $display("FAIL cofetch next: got %h want %h", fetch_next, m_read(co_addr + 1)); end
    end
    n_cmp++; if (busy !== 1'b1 || load_ready !== 1'b1) begin n_bad++; $display("FAIL load enter: busy=%b ready=%b want 1/1", busy, load_ready); end
    n_cmp++; if (load_overflow !== 1'b0) begin n_bad++; $display("FAIL load enter overflow: got %b want 0", load_overflow); end
    while (!ended && cyc < 400) begin
      v     = toggle ? phase : 1'($urandom_range(0, 1));
      phase = ~phase;
      d     = fixed ? DW'((acc + 1) * 16'h1111) : DW'($urandom);
      load_valid = v; load_data = d;
      load_last  = use_last && (acc == n - 1);
      fetch_en   = 1'($urandom_range(0, 1)); fetch_addr = AW'($urandom);
      tick();
      cyc++;
      if (v) begin
        m_mem[base + acc] = d;
        acc++;
        if (load_last || (base + acc - 1 == TOPA)) ended = 1;
      end
      n_cmp++; if (fetch_valid !== 1'b0) begin n_bad++; $display("FAIL fetch in load: valid=%b want 0", fetch_valid); end
      if (!ended) begin
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL busy in load: got %b want 1", busy); end
      end
    end
    load_valid = 1'b0; load_last = 1'b0; fetch_en = 1'b0;
    if (!ended) begin n_bad++; $display("FAIL load timeout: accepted %0d of %0d", acc, exp_acc); end
    ec = (AW + 1)'(exp_acc);
    n_cmp++; if (load_done !== 1'b1) begin n_bad++; $display("FAIL load_done: got %b want 1", load_done); end
    n_cmp++; if (load_count !== ec) begin n_bad++; $display("FAIL load_count: got %0d want %0d", load_count, ec); end
    n_cmp++; if (load_overflow !== eovf) begin n_bad++; $display("FAIL load_overflow: got %b want %b", load_overflow, eovf); end
    n_cmp++; if (busy !== 1'b0 || load_ready !== 1'b0) begin n_bad++; $display("FAIL load exit: busy=%b ready=%b want 0/0", busy, load_ready); end
    m_lo = base; m_cnt = exp_acc;
    tick();
    n_cmp++; if (load_done !== 1'b0) begin n_bad++; $display("FAIL load_done pulse width: got %b want 0", load_done); end
  endtask

  task automatic test_reset();
    #3;
    n_cmp++; if (load_ready !== 1'b0 || load_done !== 1'b0 || load_overflow !== 1'b0 || busy !== 1'b0)
      begin n_bad++; $display("FAIL reset flags: ready=%b done=%b ovf=%b busy=%b want 0", load_ready, load_done, load_overflow, busy); end
    n_cmp++; if (fetch_valid !== 1'b0 || fetch_oob !== 1'b0) begin n_bad++; $display("FAIL reset fetch flags: %b %b want 0 0", fetch_valid, fetch_oob); end
    n_cmp++; if (load_count !== '0) begin n_bad++; $display("FAIL reset load_count: got %0d want 0", load_count); end
    n_cmp++; if (fetch_data !== NOP || fetch_next !== NOP) begin n_bad++; $display("FAIL reset data: %h %h want %h", fetch_data, fetch_next, NOP); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_load();
    do_load(0, 3, 1, 0, 1, 0, 0);
    do_fetch(1, "basic_a1");
    n_cmp++; if (fetch_data !== 16'h2222) begin n_bad++; $display("FAIL basic literal: got %h want 2222", fetch_data); end
  endtask

  task automatic test_range_edge();
    do_fetch(2, "edge_a2");
    do_fetch(3, "edge_a3");
  endtask

  task automatic test_toggle_valid();
    do_load(16'h0010, 4, 1, 1, 0, 0, 0);
    do_fetch(16'h000F, "tog_below");
    do_fetch(16'h0013, "tog_last");
    do_fetch(16'h0014, "tog_above");
  endtask

  task automatic test_top_of_memory();
    do_load(TOPA - 1, 2, 1, 0, 0, 0, 0);
    do_fetch(TOPA, "top_last");
    do_fetch(TOPA - 1, "top_m1");
    do_load(TOPA - 2, 0, 0, 0, 0, 0, 0);
    do_fetch(TOPA, "ovf_top");
    do_fetch(TOPA - 3, "ovf_below");
  endtask

  task automatic test_back_to_back();
    do_load(100, 5, 1, 0, 0, 1, TOPA - 1);
    do_fetch(104, "b2b_end");
    do_load(102, 2, 1, 0, 0, 1, 104);
    do_fetch(101, "b2b_prev");
    do_fetch(102, "b2b_first");
  endtask

  task automatic test_random();
    int base, n;
    for (int it = 0; it < 6; it++) begin
      base = $urandom_range(0, TOPA - 20);
      n    = $urandom_range(1, 8);
      do_load(base, n, 1, 0, 0, 1, m_lo + $urandom_range(0, 3));
      for (int k = 0; k < 4; k++) do_fetch(base - 2 + $urandom_range(0, n + 3), "rand");
    end
  endtask

  task automatic test_small_overflow();
    logic [DW-1:0] w [4];
    int            acc;
    acc = 0;
    for (int i = 0; i < 4; i++) w[i] = DW'($urandom);
    s_load_start = 1'b1; s_load_base = 4'd14;
    tick();
    s_load_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!s_load_ready) break;
      s_load_valid = 1'b1; s_load_data = w[i]; s_load_last = 1'b0;
      tick();
      acc++;
    end
    s_load_valid = 1'b0;
    n_cmp++; if (acc !== 2) begin n_bad++; $display("FAIL small accepted: got %0d want 2", acc); end
    n_cmp++; if (s_load_done !== 1'b1) begin n_bad++; $display("FAIL small done: got %b want 1", s_load_done); end
    n_cmp++; if (s_load_count !== 5'd2) begin n_bad++; $display("FAIL small count: got %0d want 2", s_load_count); end
    n_cmp++; if (s_load_overflow !== 1'b1) begin n_bad++; $display("FAIL small overflow: got %b want 1", s_load_overflow); end
    tick();
    s_fetch_en = 1'b1; s_fetch_addr = 4'd15;
    tick();
    s_fetch_en = 1'b0;
    n_cmp++; if (s_fetch_data !== w[1] || s_fetch_next !== NOP || s_fetch_oob !== 1'b0 || s_fetch_valid !== 1'b1)
      begin n_bad++; $display("FAIL small fetch15: d=%h n=%h oob=%b v=%b want %h %h 0 1", s_fetch_data, s_fetch_next, s_fetch_oob, s_fetch_valid, w[1], NOP); end
    s_fetch_en = 1'b1; s_fetch_addr = 4'd13;
    tick();
    s_fetch_en = 1'b0;
    n_cmp++; if (s_fetch_data !== NOP || s_fetch_next !== w[0] || s_fetch_oob !== 1'b1)
      begin n_bad++; $display("FAIL small fetch13: d=%h n=%h oob=%b want %h %h 1", s_fetch_data, s_fetch_next, s_fetch_oob, NOP, w[0]); end
  endtask

  task automatic test_reset_mid_load();
    load_start = 1'b1; load_base = AW'(5);
    tick();
    load_start = 1'b0; load_valid = 1'b1; load_data = 16'hBEEF; fetch_en = 1'b1; fetch_addr = AW'(5);
    tick();
    tick();
    n_cmp++; if (fetch_valid !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL mid-load: valid=%b busy=%b want 0 1", fetch_valid, busy); end
    #2 rst_n = 1'b0;
    #1;
    load_valid = 1'b0; fetch_en = 1'b0;
    m_cnt = 0;
    n_cmp++; if (busy !== 1'b0 || load_ready !== 1'b0 || load_done !== 1'b0 || load_count !== '0 || load_overflow !== 1'b0)
      begin n_bad++; $display("FAIL async reset: busy=%b ready=%b done=%b cnt=%0d ovf=%b want all 0", busy, load_ready, load_done, load_count, load_overflow); end
    n_cmp++; if (fetch_data !== NOP || fetch_next !== NOP || fetch_valid !== 1'b0)
      begin n_bad++; $display("FAIL async reset fetch: %h %h %b", fetch_data, fetch_next, fetch_valid); end
    tick();
    rst_n = 1'b1;
    tick();
    n_cmp++; if (load_done !== 1'b0) begin n_bad++; $display("FAIL done after abandon: got %b want 0", load_done); end
    fetch_en = 1'b1; fetch_addr = '0;
    tick();
    fetch_en = 1'b0;
    n_cmp++; if (fetch_valid !== 1'b0 || fetch_data !== NOP) begin n_bad++; $display("FAIL idle fetch: valid=%b data=%h want 0 %h", fetch_valid, fetch_data, NOP); end
  endtask

  initial begin
    rst_n = 1'b0;
    load_start = 1'b0; load_base = '0; load_valid = 1'b0; load_last = 1'b0; load_data = '0;
    fetch_en = 1'b0; fetch_addr = '0;
    s_load_start = 1'b0; s_load_base = '0; s_load_valid = 1'b0; s_load_last = 1'b0; s_load_data = '0;
    s_fetch_en = 1'b0; s_fetch_addr = '0;
    test_reset();
    test_basic_load();
    test_range_edge();
    test_toggle_valid();
    test_top_of_memory();
    test_back_to_back();
    test_random();
    test_small_overflow();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
